// File: rtl/fetch_redirect_pkg.sv
// Shared types for the fetch redirect arbiter: redirect source encoding,
// FSM state encoding and the holdoff counter width.
package fetch_redirect_pkg;

   // Holds HOLDOFF_CYCLES values 1..7
   localparam int HOLDOFF_W = 3;

   typedef enum logic [2:0] {
      SRC_NONE   = 3'd0,
      SRC_TRAP   = 3'd1,
      SRC_BRANCH = 3'd2,
      SRC_FENCE  = 3'd3,
      SRC_PRED   = 3'd4
   } redirect_src_e;

   typedef enum logic [1:0] {
      ST_IDLE        = 2'd0,
      ST_HOLDOFF     = 2'd1,
      ST_FENCE_DRAIN = 2'd2
   } arb_state_e;

endpackage

// File: rtl/holdoff_counter.sv
// Down-counter tracking how many more fetch cycles carry stale data after a
// redirect. Load wins over decrement; decrement saturates at zero.
module holdoff_counter
   import fetch_redirect_pkg::*;
(
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_load,
   input  logic [HOLDOFF_W-1:0] i_load_val,
   input  logic                 i_dec,
   output logic [HOLDOFF_W-1:0] o_count,
   output logic                 o_nonzero
);

   logic [HOLDOFF_W-1:0] r_count;

   // Reload on a grant, otherwise count down on non-stalled cycles
   always_ff @(posedge i_clk) begin
      if (i_reset)
         r_count <= '0;
      else if (i_load)
         r_count <= i_load_val;
      else if (i_dec && (r_count != '0))
         r_count <= r_count - HOLDOFF_W'(1);
   end

   assign o_count   = r_count;
   assign o_nonzero = (r_count != '0);

endmodule

// File: rtl/fetch_redirect_arbiter.sv
// Arbitrates fetch redirects: trap > branch > fence.i completion > prediction.
// Trap/branch/prediction grants are combinational; fence.i completion is
// granted from the latched target once the store buffer drains.
module fetch_redirect_arbiter
   import fetch_redirect_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int HOLDOFF_CYCLES = 2
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_stall,
   input  logic            i_trap_req,
   input  logic [XLEN-1:0] i_trap_target,
   input  logic            i_branch_req,
   input  logic [XLEN-1:0] i_branch_target,
   input  logic            i_fence_req,
   input  logic [XLEN-1:0] i_fence_pc,
   input  logic            i_sb_empty,
   input  logic            i_pred_req,
   input  logic [XLEN-1:0] i_pred_target,
   output logic            o_redirect_valid,
   output logic [XLEN-1:0] o_redirect_target,
   output redirect_src_e   o_redirect_src,
   output logic            o_flush,
   output logic            o_holdoff,
   output logic            o_fence_busy,
   output logic            o_pred_accept
);

   arb_state_e           r_state;
   logic [XLEN-1:0]      r_fence_tgt;
   logic [HOLDOFF_W-1:0] w_count;
   logic                 w_nonzero;
   logic                 w_trap_g, w_br_g, w_fence_g, w_pred_g;
   logic                 w_fence_entry, w_any_grant, w_in_drain;

   assign w_in_drain = (r_state == ST_FENCE_DRAIN);

   // Trap ignores stall; everything else waits for a non-stalled cycle.
   // A raw branch request also masks lower sources: if it is stalled, the
   // redirect is still coming and nothing younger should be redirected.
   assign w_trap_g      = !i_reset && i_trap_req;
   assign w_br_g        = !i_reset && !i_trap_req && i_branch_req && !i_stall;
   assign w_fence_g     = !i_reset && w_in_drain && i_sb_empty && !i_stall
                          && !i_trap_req && !i_branch_req;
   assign w_fence_entry = !i_reset && !w_in_drain && i_fence_req
                          && !i_trap_req && !i_branch_req;
   // The fence entry flushes, so a prediction in that cycle is dropped
   assign w_pred_g      = !i_reset && i_pred_req && !i_stall && !w_nonzero
                          && !w_in_drain && !i_trap_req && !i_branch_req
                          && !i_fence_req;
   assign w_any_grant   = w_trap_g || w_br_g || w_fence_g || w_pred_g;

   holdoff_counter u_holdoff (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_load     (w_any_grant),
      .i_load_val (HOLDOFF_W'(HOLDOFF_CYCLES)),
      .i_dec      (!i_stall),
      .o_count    (w_count),
      .o_nonzero  (w_nonzero)
   );

   // Redirect FSM: any grant restarts holdoff, fence.i parks in drain
   always_ff @(posedge i_clk) begin
      if (i_reset)
         r_state <= ST_IDLE;
      else if (w_any_grant)
         r_state <= ST_HOLDOFF;
      else if (w_fence_entry)
         r_state <= ST_FENCE_DRAIN;
      else if ((r_state == ST_HOLDOFF) &&
               ((w_count == '0) || ((w_count == HOLDOFF_W'(1)) && !i_stall)))
         r_state <= ST_IDLE;
   end

   // Fence.i resumes at the instruction after itself (wraps at 2^XLEN)
   always_ff @(posedge i_clk) begin
      if (i_reset)
         r_fence_tgt <= '0;
      else if (w_fence_entry)
         r_fence_tgt <= i_fence_pc + XLEN'(4);
   end

   // Output mux; target and source are zero when nothing is granted
   always_comb begin
      o_redirect_valid  = w_any_grant;
      o_redirect_target = '0;
      o_redirect_src    = SRC_NONE;
      if (w_trap_g) begin
         o_redirect_target = i_trap_target;
         o_redirect_src    = SRC_TRAP;
      end else if (w_br_g) begin
         o_redirect_target = i_branch_target;
         o_redirect_src    = SRC_BRANCH;
      end else if (w_fence_g) begin
         o_redirect_target = r_fence_tgt;
         o_redirect_src    = SRC_FENCE;
      end else if (w_pred_g) begin
         o_redirect_target = i_pred_target;
         o_redirect_src    = SRC_PRED;
      end
   end

   assign o_flush       = w_trap_g || w_br_g || w_fence_g || w_fence_entry;
   assign o_holdoff     = !i_reset && w_nonzero;
   assign o_fence_busy  = !i_reset && w_in_drain;
   assign o_pred_accept = w_pred_g;

endmodule
